// File: rtl/mips_prog_loader_if.sv
// Bus bundle between the program loader and its environment: program
// word stream in, instruction-memory write port, register-file write and
// read ports, and register dump stream out.
interface mips_prog_loader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   // program word stream
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   // instruction-memory write port
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   // register-file write port
   logic              reg_we;
   logic [4:0]        reg_waddr;
   logic [DATA_W-1:0] reg_wdata;
   // combinational register read port
   logic [4:0]        reg_raddr;
   logic [DATA_W-1:0] reg_rdata;
   // register dump stream
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [4:0]        out_idx;

   // loader side
   modport master (
      input  in_valid, in_data, in_last, reg_rdata, out_ready,
      output in_ready, mem_we, mem_addr, mem_wdata,
             reg_we, reg_waddr, reg_wdata, reg_raddr,
             out_valid, out_data, out_idx
   );

   // environment side (stream source, memories, dump sink)
   modport slave (
      output in_valid, in_data, in_last, reg_rdata, out_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata,
             reg_we, reg_waddr, reg_wdata, reg_raddr,
             out_valid, out_data, out_idx
   );
endinterface

// File: rtl/mips_prog_loader.sv
// Program loader / sequencer for a small MIPS core: streams a program into
// instruction memory, optionally seeds the register file with Reg[k] = k,
// releases the core until it halts (or times out) and then streams out the
// first NDUMP registers.
module mips_prog_loader #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int NDUMP     = 6,
   parameter int INIT_MODE = 1,
   parameter int TMO_W     = 16
) (
   input  logic                 clk1,
   input  logic                 rst,
   input  logic                 start,
   mips_prog_loader_if.master   bus,
   output logic                 core_run,
   input  logic                 core_halted,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_INITR,
      S_RUN,
      S_DUMP,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [4:0] LAST_IDX  = 5'(NDUMP - 1);
   localparam logic [1:0] ERR_OVF   = 2'd1;
   localparam logic [1:0] ERR_TMO   = 2'd2;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [TMO_W-1:0]  tmo_inc;
   logic [4:0]        idx_q, idx_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              accept;

   assign accept = (state_q == S_LOAD) && bus.in_valid;

   // Next-state and counter update. idx_q serves as the init register
   // index in INITR and as the dump index in DUMP; it is cleared on the
   // way out of INITR so the dump always starts at R0.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      tmo_d      = tmo_q;
      idx_d      = idx_q;
      err_code_d = err_code_q;
      tmo_inc    = tmo_q + 1'b1;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_LOAD;
               wcnt_d     = '0;
               tmo_d      = '0;
               idx_d      = '0;
               err_code_d = '0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
               if (bus.in_last) begin
                  state_d = (INIT_MODE == 1) ? S_INITR : S_RUN;
               end else if (wcnt_q == '1) begin
                  state_d    = S_ERR;
                  err_code_d = ERR_OVF;
               end
            end
         end
         S_INITR: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == 5'd31) begin
               state_d = S_RUN;
               idx_d   = '0;
            end
         end
         S_RUN: begin
            if (tmo_q != '1) tmo_d = tmo_inc;
            if (core_halted) begin
               state_d = S_DUMP;
            end else if (tmo_inc == '1) begin
               state_d    = S_ERR;
               err_code_d = ERR_TMO;
            end
         end
         S_DUMP: begin
            if (bus.out_ready) begin
               if (idx_q == LAST_IDX) state_d = S_DONE;
               else                   idx_d   = idx_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         tmo_q      <= '0;
         idx_q      <= '0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         tmo_q      <= tmo_d;
         idx_q      <= idx_d;
         err_code_q <= err_code_d;
      end
   end

   // Port decode from the registered state; data/address buses are
   // forced to zero outside their owning state.
   always_comb begin
      bus.in_ready  = (state_q == S_LOAD);
      bus.mem_we    = accept;
      bus.mem_addr  = accept ? wcnt_q : '0;
      bus.mem_wdata = accept ? bus.in_data : '0;

      bus.reg_we    = (state_q == S_INITR);
      bus.reg_waddr = bus.reg_we ? idx_q : '0;
      bus.reg_wdata = bus.reg_we ? DATA_W'(idx_q) : '0;

      bus.out_valid = (state_q == S_DUMP);
      bus.reg_raddr = bus.out_valid ? idx_q : '0;
      bus.out_idx   = bus.out_valid ? idx_q : '0;
      bus.out_data  = bus.out_valid ? bus.reg_rdata : '0;

      core_run = (state_q == S_RUN);
      busy     = (state_q == S_LOAD) || (state_q == S_INITR) ||
                 (state_q == S_RUN)  || (state_q == S_DUMP);
      done     = (state_q == S_DONE);
      err      = (state_q == S_ERR);
      err_code = err_code_q;
   end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: full load/init/run/dump session
// against a small behavioural core, stalled dump, start during RUN, reset
// mid-LOAD, instruction-memory overflow and run timeout.
module tb_mips_prog_loader;

   logic clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                             32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                             32'hfc000000};
   logic [31:0] exp_r [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};

   logic rst = 1'b1;

   // ---------------- main instance (defaults) ----------------
   logic       start = 1'b0;
   logic       core_run, busy, done, err;
   logic       core_halted = 1'b0;
   logic [1:0] err_code;
   mips_prog_loader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   mips_prog_loader u_dut (
      .clk1(clk1), .rst(rst), .start(start), .bus(bus),
      .core_run(core_run), .core_halted(core_halted),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   logic [31:0] imem [1024];
   logic [31:0] rf   [32];
   logic [9:0]  pc = '0;
   int wr_cnt = 0, init_cnt = 0, dump_n = 0;
   logic        stall_pend = 1'b0;
   logic [31:0] held = '0;

   assign bus.reg_rdata = rf[bus.reg_raddr];

   // Memory/regfile sinks, behavioural core and dump scoreboard.
   always @(posedge clk1) begin : env_model
      logic [31:0] ir;
      if (bus.mem_we) begin
         check("mem_addr", 64'(bus.mem_addr), 64'(wr_cnt));
         if (wr_cnt < 9) check("mem_wdata", 64'(bus.mem_wdata), 64'(prog[wr_cnt]));
         imem[bus.mem_addr] <= bus.mem_wdata;
         wr_cnt++;
      end
      if (bus.reg_we) begin
         check("init_wdata", 64'(bus.reg_wdata), 64'(bus.reg_waddr));
         rf[bus.reg_waddr] <= bus.reg_wdata;
         init_cnt++;
      end
      if (rst || !core_run) begin
         pc          <= '0;
         core_halted <= 1'b0;
      end else if (!core_halted) begin
         ir = imem[pc];
         case (ir[31:26])
            6'h0a:   rf[ir[20:16]] <= rf[ir[25:21]] + {16'h0, ir[15:0]};
            6'h00:   rf[ir[15:11]] <= rf[ir[25:21]] + rf[ir[20:16]];
            6'h3f:   core_halted <= 1'b1;
            default: ;
         endcase
         pc <= pc + 1'b1;
      end
      if (stall_pend) begin
         check("stall_valid", 64'(bus.out_valid), 64'd1);
         check("stall_data", 64'(bus.out_data), 64'(held));
      end
      stall_pend = bus.out_valid && !bus.out_ready;
      held       = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
         check("dump_idx", 64'(bus.out_idx), 64'(dump_n));
         if (dump_n < 6) check("dump_data", 64'(bus.out_data), 64'(exp_r[dump_n]));
         dump_n++;
      end
   end

   // ---------------- overflow instance (ADDR_W = 3) ----------------
   logic       o_start = 1'b0;
   logic       o_core_run, o_busy, o_done, o_err;
   logic [1:0] o_err_code;
   int         o_wr = 0;
   mips_prog_loader_if #(.ADDR_W(3), .DATA_W(32)) ovf_bus ();
   assign ovf_bus.reg_rdata = '0;
   assign ovf_bus.out_ready = 1'b1;

   mips_prog_loader #(.ADDR_W(3)) u_ovf (
      .clk1(clk1), .rst(rst), .start(o_start), .bus(ovf_bus),
      .core_run(o_core_run), .core_halted(1'b0),
      .busy(o_busy), .done(o_done), .err(o_err), .err_code(o_err_code)
   );

   always @(posedge clk1) begin
      if (ovf_bus.mem_we) begin
         check("ovf_addr", 64'(ovf_bus.mem_addr), 64'(o_wr));
         o_wr++;
      end
   end

   // ---------------- timeout instance (TMO_W = 4, no init) ----------------
   logic       t_start = 1'b0;
   logic       t_core_run, t_busy, t_done, t_err;
   logic [1:0] t_err_code;
   int         t_run = 0;
   mips_prog_loader_if #(.ADDR_W(10), .DATA_W(32)) tmo_bus ();
   assign tmo_bus.reg_rdata = '0;
   assign tmo_bus.out_ready = 1'b1;

   mips_prog_loader #(.TMO_W(4), .INIT_MODE(0)) u_tmo (
      .clk1(clk1), .rst(rst), .start(t_start), .bus(tmo_bus),
      .core_run(t_core_run), .core_halted(1'b0),
      .busy(t_busy), .done(t_done), .err(t_err), .err_code(t_err_code)
   );

   always @(posedge clk1) if (t_core_run) t_run++;

   // One complete session on the main instance.
   task automatic run_session(input bit stall, input bit poke);
      int  n = 0;
      int  s = 0;
      bit  poked = 1'b0;
      wr_cnt   = 0;
      init_cnt = 0;
      dump_n   = 0;
      @(negedge clk1) start = 1'b1;
      @(negedge clk1) start = 1'b0;
      check("in_ready_load", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 9; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = prog[i];
         bus.in_last  = (i == 8);
         @(negedge clk1);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
      while (n < 2000 && !done && !err) begin
         start = 1'b0;
         if (poke && core_run && !poked) begin
            start = 1'b1;
            poked = 1'b1;
         end
         if (!stall)             bus.out_ready = 1'b1;
         else if (bus.out_valid) begin
            bus.out_ready = (s == 3);
            s = (s == 3) ? 0 : s + 1;
         end else                bus.out_ready = 1'b0;
         @(negedge clk1);
         n++;
      end
      start = 1'b0;
      check("sess_done", 64'(done), 64'd1);
      check("sess_err", 64'(err), 64'd0);
      check("sess_busy", 64'(busy), 64'd0);
      check("sess_writes", 64'(wr_cnt), 64'd9);
      check("sess_inits", 64'(init_cnt), 64'd32);
      check("sess_dumps", 64'(dump_n), 64'd6);
      check("sess_run_off", 64'(core_run), 64'd0);
      check("sess_oval_off", 64'(bus.out_valid), 64'd0);
      if (poke) check("poke_seen", 64'(poked), 64'd1);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
      ovf_bus.in_valid = 1'b0; ovf_bus.in_data = '0; ovf_bus.in_last = 1'b0;
      tmo_bus.in_valid = 1'b0; tmo_bus.in_data = '0; tmo_bus.in_last = 1'b0;
      repeat (3) @(negedge clk1);

      // reset state
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_reg_we", 64'(bus.reg_we), 64'd0);
      check("rst_core_run", 64'(core_run), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_status", 64'({busy, done, err, err_code}), 64'd0);
      check("rst_addrs", 64'({bus.mem_addr, bus.reg_waddr, bus.reg_raddr, bus.out_idx}), 64'd0);
      check("rst_data", 64'({bus.mem_wdata, bus.reg_wdata}), 64'd0);
      rst = 1'b0;
      @(negedge clk1);

      // overflow: 9 words, none last, 8-deep memory
      @(negedge clk1) o_start = 1'b1;
      @(negedge clk1) o_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         ovf_bus.in_valid = 1'b1;
         ovf_bus.in_data  = 32'(i);
         @(negedge clk1);
      end
      ovf_bus.in_valid = 1'b0;
      check("ovf_writes", 64'(o_wr), 64'd8);
      check("ovf_err", 64'(o_err), 64'd1);
      check("ovf_code", 64'(o_err_code), 64'd1);
      check("ovf_in_ready", 64'(ovf_bus.in_ready), 64'd0);
      check("ovf_busy", 64'(o_busy), 64'd0);

      // timeout: single halt-less word, core never halts
      @(negedge clk1) t_start = 1'b1;
      @(negedge clk1) t_start = 1'b0;
      tmo_bus.in_valid = 1'b1;
      tmo_bus.in_last  = 1'b1;
      @(negedge clk1);
      tmo_bus.in_valid = 1'b0;
      tmo_bus.in_last  = 1'b0;
      for (int n = 0; n < 100 && !t_err; n++) @(negedge clk1);
      check("tmo_err", 64'(t_err), 64'd1);
      check("tmo_code", 64'(t_err_code), 64'd2);
      check("tmo_run_cycles", 64'(t_run), 64'd15);
      check("tmo_core_run", 64'(t_core_run), 64'd0);

      // full session with a start pulse during RUN
      run_session(1'b0, 1'b1);
      // session with stalled dump
      run_session(1'b1, 1'b0);

      // reset coincident with the 4th accepted LOAD word
      wr_cnt = 0;
      @(negedge clk1) start = 1'b1;
      @(negedge clk1) start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = prog[i];
         bus.in_last  = 1'b0;
         if (i == 3) rst = 1'b1;
         @(negedge clk1);
      end
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_mem_we", 64'(bus.mem_we), 64'd0);
      run_session(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
